// File: rtl/mux2x1_arbiter_if.sv
// rtl/mux2x1_arbiter_if.sv - handshake bundle between two requesters, the arbiter and its consumer
//
// Purpose:
//   Groups the requester A/B valid/ready/data signals, the registered output
//   stage handshake and the arbiter status outputs into one interface.
//
// Signals:
//   a_valid, a_data, a_ready  requester A handshake
//   b_valid, b_data, b_ready  requester B handshake
//   d_valid, d_data, d_ready  output stage handshake
//   d_src                     source of d_data (0=A, 1=B)
//   sel                       combinational mux select (1 when B is granted)
//   cnt_a, cnt_b              saturating accepted-word counters
//
// Modports:
//   slave   arbiter side
//   master  producer/consumer side (environment)

interface mux2x1_arbiter_if #(
    parameter int DATAWIDTH  = 8,
    parameter int COUNTWIDTH = 8
);
    logic                  a_valid;
    logic [DATAWIDTH-1:0]  a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [DATAWIDTH-1:0]  b_data;
    logic                  b_ready;
    logic                  d_valid;
    logic [DATAWIDTH-1:0]  d_data;
    logic                  d_ready;
    logic                  d_src;
    logic                  sel;
    logic [COUNTWIDTH-1:0] cnt_a;
    logic [COUNTWIDTH-1:0] cnt_b;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, d_ready,
        output a_ready, b_ready, d_valid, d_data, d_src, sel, cnt_a, cnt_b
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, d_ready,
        input  a_ready, b_ready, d_valid, d_data, d_src, sel, cnt_a, cnt_b
    );
endinterface

// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - round-robin arbiter sharing one 2:1 mux into a single-entry output register
//
// Purpose:
//   Arbitrates between requesters A and B with round-robin priority, selects
//   the winner through one 2:1 mux and registers it into a one-entry output
//   stage. One word per cycle is sustained while the consumer keeps d_ready
//   high; the stage is refilled in the same cycle it is drained.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux2x1_arbiter_if.slave (requester, output and status signals)

module mux2x1_arbiter #(
    parameter int DATAWIDTH  = 8,
    parameter int COUNTWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux2x1_arbiter_if.slave       bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DATAWIDTH-1:0]  d_data_q;
    logic                  d_src_q;
    logic                  last_grant_q;   // 0=A, 1=B won the most recent accept
    logic [COUNTWIDTH-1:0] cnt_a_q;
    logic [COUNTWIDTH-1:0] cnt_b_q;

    logic                  can_accept;
    logic                  grant_a;
    logic                  grant_b;
    logic                  a_ready_w;
    logic                  b_ready_w;
    logic                  accept_a;
    logic                  accept_b;
    logic                  accept;
    logic                  sel_w;
    logic [DATAWIDTH-1:0]  mux_word;

    // The stage can take a word when empty, or when its current word leaves this cycle.
    assign can_accept = (state_q == EMPTY) || bus.d_ready;

    // Round-robin grant: on contention the source that did not win last goes next.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (can_accept) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = last_grant_q;
                grant_b = !last_grant_q;
            end else if (bus.a_valid) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    // Ready is forced low while reset is held so no handshake can be seen during reset.
    assign a_ready_w = rst_n && grant_a;
    assign b_ready_w = rst_n && grant_b;

    assign accept_a  = a_ready_w && bus.a_valid;
    assign accept_b  = b_ready_w && bus.b_valid;
    assign accept    = accept_a || accept_b;

    assign sel_w     = grant_b;
    assign mux_word  = sel_w ? bus.b_data : bus.a_data;

    // Output stage next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (bus.d_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data path register and priority pointer move only on an actual accept,
    // so idle and stalled cycles leave the rotation where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_data_q     <= '0;
            d_src_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            d_data_q     <= mux_word;
            d_src_q      <= sel_w;
            last_grant_q <= sel_w;
        end
    end

    // Saturating transfer counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (accept_a && (cnt_a_q != {COUNTWIDTH{1'b1}})) begin
                cnt_a_q <= cnt_a_q + 1'b1;
            end
            if (accept_b && (cnt_b_q != {COUNTWIDTH{1'b1}})) begin
                cnt_b_q <= cnt_b_q + 1'b1;
            end
        end
    end

    assign bus.a_ready = a_ready_w;
    assign bus.b_ready = b_ready_w;
    assign bus.sel     = sel_w;
    assign bus.d_valid = (state_q == FULL);
    assign bus.d_data  = d_data_q;
    assign bus.d_src   = d_src_q;
    assign bus.cnt_a   = cnt_a_q;
    assign bus.cnt_b   = cnt_b_q;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb/tb_mux2x1_arbiter.sv - directed self-checking bench for mux2x1_arbiter

module tb_mux2x1_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux2x1_arbiter_if #(.DATAWIDTH(8), .COUNTWIDTH(8)) m_if ();
    mux2x1_arbiter_if #(.DATAWIDTH(8), .COUNTWIDTH(2)) s_if ();

    mux2x1_arbiter #(.DATAWIDTH(8), .COUNTWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    mux2x1_arbiter #(.DATAWIDTH(8), .COUNTWIDTH(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        m_if.a_valid = 1'b1;
        m_if.a_data  = 8'd0;
        m_if.b_valid = 1'b1;
        m_if.b_data  = 8'd0;
        m_if.d_ready = 1'b1;
        s_if.a_valid = 1'b0;
        s_if.a_data  = 8'd0;
        s_if.b_valid = 1'b0;
        s_if.b_data  = 8'd0;
        s_if.d_ready = 1'b0;

        // Reset held before any clock edge
        #3;
        chk("rst_d_valid", m_if.d_valid, 0);
        chk("rst_d_data",  m_if.d_data,  0);
        chk("rst_d_src",   m_if.d_src,   0);
        chk("rst_cnt_a",   m_if.cnt_a,   0);
        chk("rst_cnt_b",   m_if.cnt_b,   0);
        chk("rst_a_ready", m_if.a_ready, 0);
        chk("rst_b_ready", m_if.b_ready, 0);
        step();
        chk("rst_hold_cnt_a", m_if.cnt_a, 0);
        chk("rst_hold_d_valid", m_if.d_valid, 0);

        // Single source A
        rst_n = 1'b1;
        m_if.a_valid = 1'b1;
        m_if.a_data  = 8'd20;
        m_if.b_valid = 1'b0;
        m_if.d_ready = 1'b1;
        #1;
        chk("single_a_ready", m_if.a_ready, 1);
        chk("single_b_ready", m_if.b_ready, 0);
        chk("single_sel",     m_if.sel,     0);
        step();
        chk("single_d_valid", m_if.d_valid, 1);
        chk("single_d_data",  m_if.d_data,  20);
        chk("single_d_src",   m_if.d_src,   0);
        chk("single_cnt_a",   m_if.cnt_a,   1);

        // Fresh reset so contention starts with A holding priority
        m_if.a_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_cnt_a", m_if.cnt_a, 0);
        step();
        rst_n = 1'b1;

        // Contention: 20,10,20,10
        m_if.a_valid = 1'b1;
        m_if.a_data  = 8'd20;
        m_if.b_valid = 1'b1;
        m_if.b_data  = 8'd10;
        m_if.d_ready = 1'b1;
        #1;
        chk("cont0_sel", m_if.sel, 0);
        chk("cont0_a_ready", m_if.a_ready, 1);
        chk("cont0_b_ready", m_if.b_ready, 0);
        step();
        chk("cont0_d_data", m_if.d_data, 20);
        chk("cont0_d_src",  m_if.d_src,  0);
        chk("cont1_sel", m_if.sel, 1);
        chk("cont1_a_ready", m_if.a_ready, 0);
        step();
        chk("cont1_d_data", m_if.d_data, 10);
        chk("cont1_d_src",  m_if.d_src,  1);
        chk("cont2_sel", m_if.sel, 0);
        step();
        chk("cont2_d_data", m_if.d_data, 20);
        chk("cont2_d_src",  m_if.d_src,  0);
        chk("cont3_sel", m_if.sel, 1);
        step();
        chk("cont3_d_data", m_if.d_data, 10);
        chk("cont3_d_src",  m_if.d_src,  1);
        chk("cont_cnt_a", m_if.cnt_a, 2);
        chk("cont_cnt_b", m_if.cnt_b, 2);

        // Drain: both idle, d_ready=1 while FULL -> EMPTY
        m_if.a_valid = 1'b0;
        m_if.b_valid = 1'b0;
        #1;
        chk("drain_a_ready", m_if.a_ready, 0);
        step();
        chk("drain_d_valid", m_if.d_valid, 0);
        step();
        chk("idle_d_valid", m_if.d_valid, 0);

        // Fill with 30 (A only; last_grant becomes A)
        m_if.a_valid = 1'b1;
        m_if.a_data  = 8'd30;
        step();
        chk("bp_fill_d_data", m_if.d_data, 30);
        chk("bp_fill_cnt_a",  m_if.cnt_a,  3);

        // Backpressure: three stalled cycles with both valid
        m_if.d_ready = 1'b0;
        m_if.a_data  = 8'd40;
        m_if.b_valid = 1'b1;
        m_if.b_data  = 8'd50;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_a_ready", m_if.a_ready, 0);
            chk("bp_b_ready", m_if.b_ready, 0);
            step();
            chk("bp_d_valid", m_if.d_valid, 1);
            chk("bp_d_data",  m_if.d_data,  30);
            chk("bp_d_src",   m_if.d_src,   0);
        end
        chk("bp_cnt_a", m_if.cnt_a, 3);
        chk("bp_cnt_b", m_if.cnt_b, 2);

        // Release: grant goes to B, opposite d_src
        m_if.d_ready = 1'b1;
        #1;
        chk("rel_b_ready", m_if.b_ready, 1);
        chk("rel_a_ready", m_if.a_ready, 0);
        chk("rel_sel",     m_if.sel,     1);
        step();
        chk("rel_d_data", m_if.d_data, 50);
        chk("rel_d_src",  m_if.d_src,  1);
        chk("rel_cnt_b",  m_if.cnt_b,  3);

        // Reset mid-operation holding 15
        m_if.a_data  = 8'd15;
        m_if.b_valid = 1'b0;
        step();
        chk("mid_d_data", m_if.d_data, 15);
        chk("mid_cnt_a",  m_if.cnt_a,  4);
        m_if.d_ready = 1'b0;
        m_if.a_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", m_if.d_valid, 0);
        chk("mid_rst_d_data",  m_if.d_data,  0);
        chk("mid_rst_cnt_a",   m_if.cnt_a,   0);
        chk("mid_rst_cnt_b",   m_if.cnt_b,   0);
        step();
        rst_n = 1'b1;
        m_if.a_valid = 1'b1;
        m_if.a_data  = 8'd15;
        m_if.b_valid = 1'b1;
        m_if.b_data  = 8'd25;
        m_if.d_ready = 1'b1;
        #1;
        chk("post_rst_a_ready", m_if.a_ready, 1);
        chk("post_rst_sel",     m_if.sel,     0);
        step();
        chk("post_rst_d_data", m_if.d_data, 15);
        chk("post_rst_d_src",  m_if.d_src,  0);
        chk("post_rst_cnt_a",  m_if.cnt_a,  1);
        m_if.a_valid = 1'b0;
        m_if.b_valid = 1'b0;

        // Saturation on the COUNTWIDTH=2 instance: five B accepts
        s_if.b_valid = 1'b1;
        s_if.d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.b_data = 8'(i + 1);
            step();
            chk("sat_d_data", s_if.d_data, i + 1);
            chk("sat_cnt_b",  s_if.cnt_b,  (i < 3) ? i + 1 : 3);
        end
        chk("sat_cnt_a", s_if.cnt_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
